instr_fetch_seq: RTL

//  Instruction fetch/sequencer for the 16-bit single-cycle CPU: owns the PC, fetches words

---
 rtl/instr_fetch_seq.sv | 138 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch / sequencer for the 16-bit single-cycle CPU.
// Owns the PC, fetches instruction words over a req/ack handshake, presents
// opcode/funct to the control unit and selects the next PC from the control
// unit's Branch/Jump/Jump_Branch outputs and the ALU zero flag.
module instr_fetch_seq #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            hold,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     instr,
  output logic [3:0]      opcode,
  output logic [3:0]      Funct_field,
  output logic            instr_valid,
  input  logic            Branch,
  input  logic            Jump,
  input  logic            Jump_Branch,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     retired,
  output logic            illegal_op
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam logic [3:0] OP_BEQ     = 4'b0100;
  localparam logic [3:0] OP_BNE     = 4'b0101;
  localparam logic [3:0] OP_ILL_MIN = 4'b0111;

  state_t          state;
  state_t          state_nx;
  logic            latch_instr;
  logic            advance;
  logic            is_illegal;
  logic            br_taken;
  logic [PC_W-1:0] pc1;
  logic [PC_W-1:0] br_off;
  logic [PC_W-1:0] next_pc;

  // Decode fields are a pure function of the latched instruction.
  assign opcode      = instr[15:12];
  assign Funct_field = instr[3:0];

  // Address is only driven while a request is outstanding.
  assign imem_addr = imem_req ? pc : '0;

  // Next-PC selection; illegal opcodes and inconsistent control fall through to pc+1.
  always_comb begin
    pc1        = pc + PC_W'(1);
    br_off     = {{(PC_W-6){instr[5]}}, instr[5:0]};
    is_illegal = (opcode >= OP_ILL_MIN);
    br_taken   = Branch && (((opcode == OP_BEQ) && zero) ||
                            ((opcode == OP_BNE) && !zero));
    next_pc    = pc1;
    if (!is_illegal && Jump_Branch) begin
      if (Jump) begin
        next_pc = {pc1[PC_W-1:12], instr[11:0]};
      end else if (br_taken) begin
        next_pc = pc1 + br_off;
      end
    end
  end

  // Next-state and Moore/Mealy outputs of the fetch/execute sequencer.
  always_comb begin
    state_nx    = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    illegal_op  = 1'b0;
    latch_instr = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_nx = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          latch_instr = 1'b1;
          state_nx    = EXEC;
        end
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!hold) begin
          advance    = 1'b1;
          illegal_op = is_illegal;
          state_nx   = run ? FETCH : IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Instruction register, loaded on the acknowledged fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= '0;
    end else if (latch_instr) begin
      instr <= imem_rdata;
    end
  end

  // PC and retired-instruction counter advance when EXEC completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= RESET_PC;
      retired <= '0;
    end else if (advance) begin
      pc      <= next_pc;
      retired <= retired + 16'd1;
    end
  end

endmodule
